// File: rtl/ram_be.sv
// Byte-addressable 32-bit data memory for the MEM stage: byte/half/word stores with lane
// enables, sign/zero-extended loads, access-fault detection and a hardware clear sequencer.
module ram_be #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH+1:0] addr,
  input  logic [31:0]           din,
  input  logic                  WE,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  output logic [31:0]           dout,
  output logic                  busy,
  output logic                  misaligned
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {S_CLEAR, S_READY} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [31:0]             mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   widx;
  logic [1:0]              off;
  logic                    clear_we, store_we;
  logic [3:0]              be;
  logic [31:0]             wdata;
  logic [31:0]             rword;
  logic [7:0]              rbyte;
  logic [15:0]             rhalf;

  assign widx = addr[ADDR_WIDTH+1:2];
  assign off  = addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // The pointer is compared against the last index before it can wrap.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == S_CLEAR) begin
      ptr_d = ptr_q + 1'b1;
      if (&ptr_q) state_d = S_READY;
    end
  end

  always_comb begin
    busy     = (state_q == S_CLEAR);
    clear_we = busy && !rst;
    store_we = !busy && !rst && WE && !misaligned;
  end

  always_comb begin
    unique case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    be    = 4'b0000;
    wdata = din;
    unique case (size)
      2'b00: begin
        be    = 4'b0001 << off;
        wdata = {4{din[7:0]}};
      end
      2'b01: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{din[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[ptr_q] <= '0;
    end else if (store_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Asynchronous read: a store becomes visible right after its edge, no bypass.
  always_comb begin
    rword = mem[widx];
    unique case (off)
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    rhalf = off[1] ? rword[31:16] : rword[15:0];
    dout  = '0;
    if (!busy && !misaligned) begin
      unique case (size)
        2'b00:   dout = {{24{sign_ext & rbyte[7]}}, rbyte};
        2'b01:   dout = {{16{sign_ext & rhalf[15]}}, rhalf};
        2'b10:   dout = rword;
        default: dout = '0;
      endcase
    end
  end

endmodule
